// File: rtl/score_bcd_converter.sv
// ============================================================================
// score_bcd_converter : multi-channel binary-to-BCD converter (double dabble)
//   with saturation to all-9s and per-channel overflow flags.
// Revision: 1.0
// ============================================================================
`default_nettype none

module score_bcd_converter #(
  parameter int WIDTH    = 7,
  parameter int DIGITS   = 2,
  parameter int CHANNELS = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [CHANNELS*WIDTH-1:0]    bin_in,
  output logic                         busy,
  output logic                         done,
  output logic [CHANNELS*DIGITS*4-1:0] bcd_out,
  output logic [CHANNELS-1:0]          overflow
);

  localparam int                BW       = DIGITS * 4;
  localparam int                CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(WIDTH - 1);
  localparam logic [31:0]       LIMIT    = 32'(10 ** DIGITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [CHANNELS*WIDTH-1:0]   bin_q, bin_d;
  logic [CHANNELS*BW-1:0]      acc_q, acc_d;
  logic [CHANNELS-1:0]         ovf_pend_q, ovf_pend_d;
  logic [CHANNELS*BW-1:0]      bcd_q, bcd_d;
  logic [CHANNELS-1:0]         ovf_q, ovf_d;
  logic                        done_q, done_d;

  logic [CHANNELS*BW-1:0]      acc_sh;
  logic [CHANNELS*WIDTH-1:0]   bin_sh;
  logic [CHANNELS*BW-1:0]      load_bcd;
  logic [CHANNELS-1:0]         ovf_cap;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [BW-1:0]       adj;
    logic [BW+WIDTH-1:0] cat;

    always_comb begin
      adj = acc_q[c*BW +: BW];
      for (int d = 0; d < DIGITS; d++) begin
        if (adj[d*4 +: 4] >= 4'd5) adj[d*4 +: 4] = adj[d*4 +: 4] + 4'd3;
      end
    end

    // Carries out of the top digit are dropped; overflow saturation covers them.
    assign cat = {adj, bin_q[c*WIDTH +: WIDTH]} << 1;
    assign acc_sh[c*BW +: BW]       = cat[BW+WIDTH-1 -: BW];
    assign bin_sh[c*WIDTH +: WIDTH] = cat[WIDTH-1:0];
    assign ovf_cap[c]               = 32'(bin_in[c*WIDTH +: WIDTH]) >= LIMIT;
    assign load_bcd[c*BW +: BW]     = ovf_pend_q[c] ? {DIGITS{4'd9}} : acc_q[c*BW +: BW];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bin_d      = bin_q;
    acc_d      = acc_q;
    ovf_pend_d = ovf_pend_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          bin_d      = bin_in;
          acc_d      = '0;
          ovf_pend_d = ovf_cap;
          cnt_d      = CNT_INIT;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        acc_d = acc_sh;
        bin_d = bin_sh;
        if (cnt_q == '0) state_d = LOAD;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      LOAD: begin
        bcd_d   = load_bcd;
        ovf_d   = ovf_pend_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bin_q      <= '0;
      acc_q      <= '0;
      ovf_pend_q <= '0;
      bcd_q      <= '0;
      ovf_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bin_q      <= bin_d;
      acc_q      <= acc_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign bcd_out  = bcd_q;
  assign overflow = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_score_bcd_converter.sv
// ============================================================================
// tb_score_bcd_converter : directed self-checking bench for score_bcd_converter
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_score_bcd_converter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [13:0] bin_in = '0;
  logic        busy, done;
  logic [15:0] bcd_out;
  logic [1:0]  overflow;

  logic        start3 = 1'b0;
  logic [29:0] bin3 = '0;
  logic        busy3, done3;
  logic [35:0] bcd3;
  logic [2:0]  ovf3;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  score_bcd_converter dut (
    .clk(clk), .reset(reset), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .bcd_out(bcd_out), .overflow(overflow)
  );

  score_bcd_converter #(.WIDTH(10), .DIGITS(3), .CHANNELS(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .bin_in(bin3),
    .busy(busy3), .done(done3), .bcd_out(bcd3), .overflow(ovf3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_conv(input logic [6:0] a, input logic [6:0] b, output int lat);
    bin_in = {b, a};
    start  = 1'b1;
    tick();
    start  = 1'b0;
    lat    = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    tests++;
    if ({busy, done, bcd_out, overflow} !== 20'h0) begin
      fails++;
      $display("FAIL reset_state: busy=%b done=%b bcd=%h ovf=%b, required all 0",
               busy, done, bcd_out, overflow);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int lat;
    run_conv(7'd42, 7'd7, lat);
    tests++;
    if (lat !== 8) begin fails++; $display("FAIL basic_latency: got %0d required 8", lat); end
    tests++;
    if (bcd_out !== 16'h0742) begin fails++; $display("FAIL basic_bcd: got %h required 0742", bcd_out); end
    tests++;
    if (overflow !== 2'b00) begin fails++; $display("FAIL basic_ovf: got %b required 00", overflow); end
    tick();
    tick();
    tests++;
    if (done !== 1'b0 || busy !== 1'b0 || bcd_out !== 16'h0742) begin
      fails++;
      $display("FAIL basic_hold: done=%b busy=%b bcd=%h, required 0 0 0742", done, busy, bcd_out);
    end
  endtask

  task automatic test_saturate();
    int lat;
    run_conv(7'd99, 7'd100, lat);
    tests++;
    if (lat !== 8 || bcd_out !== 16'h9999 || overflow !== 2'b10) begin
      fails++;
      $display("FAIL sat_99_100: lat=%0d bcd=%h ovf=%b, required 8 9999 10", lat, bcd_out, overflow);
    end
    run_conv(7'd127, 7'd0, lat);
    tests++;
    if (lat !== 8 || bcd_out !== 16'h0099 || overflow !== 2'b01) begin
      fails++;
      $display("FAIL sat_127_0: lat=%0d bcd=%h ovf=%b, required 8 0099 01", lat, bcd_out, overflow);
    end
    run_conv(7'd0, 7'd55, lat);
    tests++;
    if (lat !== 8 || bcd_out !== 16'h5500 || overflow !== 2'b00) begin
      fails++;
      $display("FAIL zero_in: lat=%0d bcd=%h ovf=%b, required 8 5500 00", lat, bcd_out, overflow);
    end
    run_conv(7'd68, 7'd93, lat);
    tests++;
    if (lat !== 8 || bcd_out !== 16'h9368 || overflow !== 2'b00) begin
      fails++;
      $display("FAIL mixed_68_93: lat=%0d bcd=%h ovf=%b, required 8 9368 00", lat, bcd_out, overflow);
    end
  endtask

  task automatic test_ignore_start();
    int ndone = 0;
    int edge_at = -1;
    bin_in = {7'd34, 7'd12};
    start  = 1'b1;
    tick();                       // edge N
    start  = 1'b0;
    tick();                       // N+1
    tick();                       // N+2
    bin_in = {7'd88, 7'd77};
    start  = 1'b1;
    tick();                       // N+3: must be ignored
    start  = 1'b0;
    for (int e = 4; e <= 15; e++) begin
      tick();
      if (done) begin
        ndone++;
        edge_at = e;
      end
    end
    tests++;
    if (ndone !== 1 || edge_at !== 8) begin
      fails++;
      $display("FAIL ignore_start_done: count=%0d edge=%0d, required 1 at 8", ndone, edge_at);
    end
    tests++;
    if (bcd_out !== 16'h3412 || overflow !== 2'b00) begin
      fails++;
      $display("FAIL ignore_start_data: bcd=%h ovf=%b, required 3412 00", bcd_out, overflow);
    end
  endtask

  task automatic test_reset_abort();
    int ndone = 0;
    int lat;
    bin_in = {7'd6, 7'd5};
    start  = 1'b1;
    tick();                       // N
    start  = 1'b0;
    tick();
    tick();
    tick();                       // N+3
    reset  = 1'b1;
    tick();                       // N+4
    tests++;
    if ({busy, done, bcd_out, overflow} !== 20'h0) begin
      fails++;
      $display("FAIL abort_clear: busy=%b done=%b bcd=%h ovf=%b, required all 0",
               busy, done, bcd_out, overflow);
    end
    reset = 1'b0;
    for (int e = 0; e < 10; e++) begin
      tick();
      if (done) ndone++;
    end
    tests++;
    if (ndone !== 0) begin fails++; $display("FAIL abort_no_done: got %0d pulses required 0", ndone); end
    run_conv(7'd81, 7'd3, lat);
    tests++;
    if (lat !== 8 || bcd_out !== 16'h0381 || overflow !== 2'b00) begin
      fails++;
      $display("FAIL abort_restart: lat=%0d bcd=%h ovf=%b, required 8 0381 00", lat, bcd_out, overflow);
    end
  endtask

  task automatic test_back_to_back();
    int ndone = 0;
    logic        exp_done;
    int          v;
    logic [15:0] exp_bcd;
    bin_in = {7'd50, 7'd0};
    start  = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick();                     // edge k samples ch0 = k % 13
      exp_done = (k >= 8) && (((k - 8) % 9) == 0);
      tests++;
      if (done !== exp_done) begin
        fails++;
        $display("FAIL b2b_done_edge%0d: got %b required %b", k, done, exp_done);
      end
      if (exp_done && done) begin
        ndone++;
        v       = (k - 8) % 13;
        exp_bcd = {8'h50, 4'(v / 10), 4'(v % 10)};
        tests++;
        if (bcd_out !== exp_bcd) begin
          fails++;
          $display("FAIL b2b_data_edge%0d: got %h required %h", k, bcd_out, exp_bcd);
        end
      end
      bin_in = {7'd50, 7'((k + 1) % 13)};
    end
    start = 1'b0;
    tests++;
    if (ndone !== 3) begin fails++; $display("FAIL b2b_count: got %0d required 3", ndone); end
    for (int k = 0; k < 12; k++) tick();
  endtask

  task automatic test_wide(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c,
                           input logic [35:0] exp_bcd, input logic [2:0] exp_ovf);
    int lat = -1;
    bin3   = {c, b, a};
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (done3) begin
        lat = k;
        break;
      end
    end
    tests++;
    if (lat !== 11 || bcd3 !== exp_bcd || ovf3 !== exp_ovf) begin
      fails++;
      $display("FAIL wide_%0d_%0d_%0d: lat=%0d bcd=%h ovf=%b, required 11 %h %b",
               a, b, c, lat, bcd3, ovf3, exp_bcd, exp_ovf);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    test_wide(10'd999, 10'd1000, 10'd0, {12'h000, 12'h999, 12'h999}, 3'b010);
    test_wide(10'd123, 10'd1023, 10'd500, {12'h500, 12'h999, 12'h123}, 3'b010);
    test_wide(10'd7, 10'd80, 10'd1001, {12'h999, 12'h080, 12'h007}, 3'b100);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
